game_flow_ctrl: RTL and testbench

- Parametrised top-level game flow controller. Tracks game state, multi-source scoring, level progression, pause, win/lose and easter-egg entry.
- Clocked once per video frame. Sits between the keyboard/player/enemy logic and the renderer. The renderer consumes the one-hot state flags, score, high score and level.
- Over its predecessor it adds:
  - N hit channels with saturating score
  - multiple levels with a timed clear screen
  - edge-detected pause
  - persistent high score
  - restart without reset

---
 rtl/game_flow_ctrl_if.sv | 40 ++++
 rtl/game_flow_ctrl.sv | 169 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_if.sv
// Frame-rate bus between the game logic, the flow controller and the renderer.
// Handshake: there is no valid/ready pair; every signal is valid for one whole
// frame and is sampled on each rising frame_clk edge (every frame is a transfer).
interface game_flow_ctrl_if #(
  parameter int N_HIT   = 4,
  parameter int SCORE_W = 16,
  parameter int LVL_W   = 1
);
  // Inputs from keyboard / player / enemy logic
  logic [7:0]         keycode;
  logic [N_HIT-1:0]   hit;
  logic [2:0]         lives_lost;
  logic [9:0]         playerX;
  // One-hot state flags and game data towards the renderer
  logic               start;
  logic               play;
  logic               paused;
  logic               level_clear;
  logic               over;
  logic               win;
  logic               egg;
  logic [LVL_W-1:0]   level;
  logic               level_load;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;

  // Game-logic / renderer side
  modport master (
    output keycode, hit, lives_lost, playerX,
    input  start, play, paused, level_clear, over, win, egg,
    input  level, level_load, score, high_score
  );

  // Flow controller side
  modport slave (
    input  keycode, hit, lives_lost, playerX,
    output start, play, paused, level_clear, over, win, egg,
    output level, level_load, score, high_score
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow controller: game state, saturating multi-source score, level
// progression with a timed clear screen, edge-detected pause, persistent
// high score and restart without reset. Clocked once per video frame.
module game_flow_ctrl #(
  parameter int N_HIT        = 4,
  parameter int SCORE_W      = 16,
  parameter int PTS_PER_HIT  = 10,
  parameter int MAX_LIVES    = 3,
  parameter int N_LEVELS     = 2,
  parameter int LEVEL_END_X  = 649,
  parameter int CLEAR_FRAMES = 120,
  parameter int KEY_START    = 40,
  parameter int KEY_PAUSE    = 19,
  localparam int LVL_W       = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
  input  logic             frame_clk,
  input  logic             Reset,
  game_flow_ctrl_if.slave  bus,
  output logic [6:0]       o_state_dbg
);

  localparam int HIT_W = $clog2(N_HIT + 1);
  localparam int SUM_W = SCORE_W + $clog2(N_HIT) + 8;
  localparam int TMR_W = $clog2(CLEAR_FRAMES + 1);

  // One-hot encoding: each state bit is directly one renderer flag.
  typedef enum logic [6:0] {
    S_START  = 7'b0000001,
    S_PLAY   = 7'b0000010,
    S_PAUSED = 7'b0000100,
    S_LCLEAR = 7'b0001000,
    S_OVER   = 7'b0010000,
    S_WIN    = 7'b0100000,
    S_EGG    = 7'b1000000
  } state_t;

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [LVL_W-1:0]   r_level;
  logic               r_level_load;
  logic [TMR_W-1:0]   r_timer;
  logic               r_armed;
  logic [7:0]         r_key_prev;

  logic [HIT_W-1:0]   w_hit_cnt;
  logic [SUM_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_score_upd;
  logic [SCORE_W-1:0] w_hs_cand;
  logic               w_scoring;
  logic               w_press_start;
  logic               w_press_pause;
  logic               w_beyond;
  logic               w_end;
  logic               w_lives_out;
  logic               w_last_level;

  // Count the asserted hit sources this frame.
  always_comb begin
    w_hit_cnt = '0;
    for (int i = 0; i < N_HIT; i++) begin
      w_hit_cnt = w_hit_cnt + HIT_W'(bus.hit[i]);
    end
  end

  // Wide add, then clamp to the all-ones score instead of wrapping.
  assign w_sum       = SUM_W'(r_score) + SUM_W'(PTS_PER_HIT) * SUM_W'(w_hit_cnt);
  assign w_score_upd = (w_sum[SUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}}
                                                      : w_sum[SCORE_W-1:0];
  assign w_hs_cand   = (w_score_upd > r_high) ? w_score_upd : r_high;

  assign w_scoring     = (r_state == S_PLAY) || (r_state == S_EGG);
  assign w_press_start = (bus.keycode == 8'(KEY_START)) && (r_key_prev != 8'(KEY_START));
  assign w_press_pause = (bus.keycode == 8'(KEY_PAUSE)) && (r_key_prev != 8'(KEY_PAUSE));
  assign w_beyond      = bus.playerX > 10'(LEVEL_END_X);
  assign w_end         = r_armed && w_beyond;
  assign w_lives_out   = bus.lives_lost >= 3'(MAX_LIVES);
  assign w_last_level  = r_level == LVL_W'(N_LEVELS - 1);

  // State, score, level and arming; later assignments override earlier defaults.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= S_START;
      r_score      <= '0;
      r_high       <= '0;
      r_level      <= '0;
      r_level_load <= 1'b0;
      r_timer      <= '0;
      r_armed      <= 1'b0;
      r_key_prev   <= '0;
    end else begin
      r_key_prev   <= bus.keycode;
      r_level_load <= 1'b0;
      if (w_scoring) begin
        r_score <= w_score_upd;
        // Arming needs the player back inside the level before it can end.
        if (!w_beyond) r_armed <= 1'b1;
      end
      case (r_state)
        S_START: begin
          if (w_press_start) begin
            r_state      <= S_PLAY;
            r_level_load <= 1'b1;
            r_score      <= '0;
            r_level      <= '0;
            r_armed      <= 1'b0;
          end
        end
        S_PLAY: begin
          if (w_lives_out) begin
            r_state <= S_OVER;
            r_high  <= w_hs_cand;
          end else if ((r_level == '0) && (r_score == '0) &&
                       (bus.lives_lost == '0) && w_end) begin
            r_state <= S_EGG;
            r_armed <= 1'b0;
          end else if (w_end) begin
            if (w_last_level) begin
              r_state <= S_WIN;
              r_high  <= w_hs_cand;
            end else begin
              r_state <= S_LCLEAR;
              r_timer <= '0;
            end
          end else if (w_press_pause) begin
            r_state <= S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (w_press_pause) r_state <= S_PLAY;
        end
        S_LCLEAR: begin
          if (r_timer == TMR_W'(CLEAR_FRAMES - 1)) begin
            r_state      <= S_PLAY;
            r_level      <= r_level + LVL_W'(1);
            r_armed      <= 1'b0;
            r_level_load <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_EGG: begin
          if (w_lives_out || w_end) begin
            r_state <= S_OVER;
            r_high  <= w_hs_cand;
          end
        end
        S_OVER, S_WIN: begin
          if (w_press_start) r_state <= S_START;
        end
        default: r_state <= S_START;
      endcase
    end
  end

  assign bus.start       = r_state[0];
  assign bus.play        = r_state[1];
  assign bus.paused      = r_state[2];
  assign bus.level_clear = r_state[3];
  assign bus.over        = r_state[4];
  assign bus.win         = r_state[5];
  assign bus.egg         = r_state[6];
  assign bus.level       = r_level;
  assign bus.level_load  = r_level_load;
  assign bus.score       = r_score;
  assign bus.high_score  = r_high;
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: a frame driver feeds directed scenarios and random
// frames, a reference model predicts the outputs after each edge and queues
// them, and an independent monitor pops and compares every frame.
module tb_game_flow_ctrl;
  localparam int N_HIT     = 4;
  localparam int SCORE_W   = 16;
  localparam int PTS       = 10;
  localparam int MAX_LIVES = 3;
  localparam int N_LEVELS  = 2;
  localparam int LVL_W     = 1;
  localparam int END_X     = 649;
  localparam int CLEAR     = 120;
  localparam int K_START   = 40;
  localparam int K_PAUSE   = 19;
  localparam int EXP_W     = 7 + LVL_W + 1 + 2 * SCORE_W;
  localparam longint SMAX  = (longint'(1) << SCORE_W) - 1;

  // Model state indices; flag bit i of the expected vector is state i.
  localparam int M_START = 0, M_PLAY = 1, M_PAUSED = 2, M_LCLEAR = 3;
  localparam int M_OVER  = 4, M_WIN  = 5, M_EGG    = 6;

  // ---------------- clock / reset ----------------
  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic [6:0] dbg_state;
  always #5 frame_clk = ~frame_clk;

  game_flow_ctrl_if #(.N_HIT(N_HIT), .SCORE_W(SCORE_W), .LVL_W(LVL_W)) bus ();

  game_flow_ctrl #(
    .N_HIT(N_HIT), .SCORE_W(SCORE_W), .PTS_PER_HIT(PTS), .MAX_LIVES(MAX_LIVES),
    .N_LEVELS(N_LEVELS), .LEVEL_END_X(END_X), .CLEAR_FRAMES(CLEAR),
    .KEY_START(K_START), .KEY_PAUSE(K_PAUSE)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .bus         (bus),
    .o_state_dbg (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;

  // ---------------- reference model ----------------
  int         m_st;
  int         m_level;
  int         m_clear_seen;
  bit         m_load;
  bit         m_armed;
  longint     m_score;
  longint     m_high;
  logic [7:0] m_kprev;

  task automatic model_step(input bit rst, input logic [7:0] key,
                            input logic [N_HIT-1:0] hit, input logic [2:0] lives,
                            input logic [9:0] x);
    int     nst;
    longint s_new;
    bit     ps, pp, beyond, lose, fin;
    if (rst) begin
      m_st = M_START; m_level = 0; m_clear_seen = 0; m_load = 0;
      m_armed = 0; m_score = 0; m_high = 0; m_kprev = 8'd0;
      return;
    end
    ps     = (key == 8'(K_START)) && (m_kprev != 8'(K_START));
    pp     = (key == 8'(K_PAUSE)) && (m_kprev != 8'(K_PAUSE));
    beyond = int'(x) > END_X;
    lose   = int'(lives) >= MAX_LIVES;
    fin    = m_armed && beyond;
    nst    = m_st;
    s_new  = m_score;
    m_load = 0;
    if (m_st == M_PLAY || m_st == M_EGG) begin
      s_new = m_score + longint'(PTS) * longint'($countones(hit));
      if (s_new > SMAX) s_new = SMAX;
      if (!beyond) m_armed = 1;
    end
    if (m_st == M_START && ps) begin
      nst = M_PLAY; m_load = 1; s_new = 0; m_level = 0; m_armed = 0;
    end else if (m_st == M_PLAY) begin
      if (lose) nst = M_OVER;
      else if (m_level == 0 && m_score == 0 && lives == 0 && fin) begin
        nst = M_EGG; m_armed = 0;
      end else if (fin) begin
        if (m_level == N_LEVELS - 1) nst = M_WIN;
        else begin nst = M_LCLEAR; m_clear_seen = 0; end
      end else if (pp) nst = M_PAUSED;
    end else if (m_st == M_PAUSED && pp) begin
      nst = M_PLAY;
    end else if (m_st == M_LCLEAR) begin
      m_clear_seen++;
      if (m_clear_seen == CLEAR) begin
        nst = M_PLAY; m_level++; m_armed = 0; m_load = 1;
      end
    end else if (m_st == M_EGG && (lose || fin)) begin
      nst = M_OVER;
    end else if ((m_st == M_OVER || m_st == M_WIN) && ps) begin
      nst = M_START;
    end
    // Best score is captured as the game finishes.
    if ((nst == M_OVER || nst == M_WIN) && nst != m_st && s_new > m_high)
      m_high = s_new;
    m_score = s_new;
    m_st    = nst;
    m_kprev = key;
  endtask

  function automatic logic [EXP_W-1:0] model_pack();
    logic [6:0] fl;
    fl = 7'd1 << m_st;
    return {fl, LVL_W'(m_level), m_load, SCORE_W'(m_score), SCORE_W'(m_high)};
  endfunction

  // ---------------- driver ----------------
  task automatic frame(input bit rst, input logic [7:0] key,
                       input logic [N_HIT-1:0] hit, input logic [2:0] lives,
                       input logic [9:0] x);
    @(negedge frame_clk);
    Reset          = rst;
    bus.keycode    = key;
    bus.hit        = hit;
    bus.lives_lost = lives;
    bus.playerX    = x;
    model_step(rst, key, hit, lives, x);
    exp_q.push_back(model_pack());
  endtask

  task automatic idle(input int n, input logic [9:0] x);
    for (int i = 0; i < n; i++) frame(1'b0, 8'd0, '0, 3'd0, x);
  endtask

  task automatic do_reset();
    frame(1'b1, 8'd0, '0, 3'd0, 10'd0);
    frame(1'b1, 8'd0, '0, 3'd0, 10'd0);
  endtask

  task automatic press_start();
    frame(1'b0, 8'(K_START), '0, 3'd0, 10'd100);
    frame(1'b0, 8'd0, '0, 3'd0, 10'd100);
  endtask

  task automatic rand_frames(input int n);
    logic [7:0] k;
    logic [2:0] l;
    logic [9:0] x;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        3:       k = 8'(K_PAUSE);
        4:       k = 8'(K_START);
        5:       k = 8'd7;
        default: k = 8'd0;
      endcase
      l = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(1, 4));
      x = ($urandom_range(0, 99) < 80) ? 10'($urandom_range(0, END_X))
                                        : 10'($urandom_range(END_X + 1, 1023));
      frame(1'b0, k, N_HIT'($urandom_range(0, 15)), l, x);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s frame %0d got %0h expected %0h", name, frame_no, got, exp);
    end
  endtask

  initial begin
    logic [EXP_W-1:0] e;
    logic [6:0]       fl;
    forever begin
      @(posedge frame_clk);
      #1;
      frame_no++;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        fl = {bus.egg, bus.win, bus.over, bus.level_clear, bus.paused, bus.play, bus.start};
        check("flags",      32'(fl),             32'(e[EXP_W-1 -: 7]));
        check("onehot",     32'($countones(fl)), 32'd1);
        check("level",      32'(bus.level),      32'(e[2*SCORE_W+1 +: LVL_W]));
        check("level_load", 32'(bus.level_load), 32'(e[2*SCORE_W]));
        check("score",      32'(bus.score),      32'(e[SCORE_W +: SCORE_W]));
        check("high_score", 32'(bus.high_score), 32'(e[SCORE_W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.keycode = 8'd0; bus.hit = '0; bus.lives_lost = 3'd0; bus.playerX = 10'd0;

    // Start with Enter held 5 frames, then a 3-source hit.
    do_reset();
    for (int i = 0; i < 5; i++) frame(1'b0, 8'(K_START), '0, 3'd0, 10'd100);
    frame(1'b0, 8'd0, 4'b1011, 3'd0, 10'd100);
    idle(2, 10'd100);

    // Two levels with clear screen, held-beyond no-win, then win.
    do_reset();
    press_start();
    frame(1'b0, 8'd0, 4'b0001, 3'd0, 10'd100);
    frame(1'b0, 8'd0, '0, 3'd0, 10'd700);
    idle(CLEAR + 6, 10'd700);
    idle(2, 10'd100);
    idle(2, 10'd700);
    frame(1'b0, 8'(K_START), '0, 3'd0, 10'd700);
    idle(2, 10'd100);

    // Lives exhausted in the same frame as level end, then restart.
    do_reset();
    press_start();
    frame(1'b0, 8'd0, 4'b1111, 3'd0, 10'd100);
    frame(1'b0, 8'd0, 4'b0001, 3'd2, 10'd100);
    frame(1'b0, 8'd0, '0, 3'd3, 10'd700);
    idle(2, 10'd700);
    frame(1'b0, 8'(K_START), '0, 3'd0, 10'd100);
    idle(2, 10'd100);

    // Pause: held key toggles once, hits ignored, reset while paused.
    do_reset();
    press_start();
    frame(1'b0, 8'd0, 4'b0011, 3'd0, 10'd100);
    for (int i = 0; i < 3; i++) frame(1'b0, 8'(K_PAUSE), 4'b1111, 3'd0, 10'd100);
    frame(1'b0, 8'd0, 4'b1111, 3'd0, 10'd100);
    frame(1'b0, 8'(K_PAUSE), 4'b0101, 3'd0, 10'd100);
    frame(1'b0, 8'd0, 4'b0001, 3'd0, 10'd100);
    frame(1'b0, 8'(K_PAUSE), '0, 3'd0, 10'd100);
    frame(1'b1, 8'd0, '0, 3'd0, 10'd100);

    // Easter egg, then exit to game over via re-arm and level end.
    do_reset();
    press_start();
    frame(1'b0, 8'd0, '0, 3'd0, 10'd700);
    frame(1'b0, 8'd0, '0, 3'd0, 10'd700);
    frame(1'b0, 8'd0, 4'b0010, 3'd0, 10'd100);
    frame(1'b0, 8'd0, '0, 3'd0, 10'd700);
    idle(2, 10'd700);

    // Reset in the middle of the clear screen.
    do_reset();
    press_start();
    frame(1'b0, 8'd0, 4'b0001, 3'd0, 10'd100);
    frame(1'b0, 8'd0, '0, 3'd0, 10'd700);
    idle(10, 10'd700);
    do_reset();
    idle(2, 10'd100);

    // Saturation: all sources every frame until the score clamps.
    press_start();
    for (int i = 0; i < 1700; i++) frame(1'b0, 8'd0, 4'b1111, 3'd0, 10'd100);
    frame(1'b0, 8'd0, '0, 3'd3, 10'd100);
    idle(2, 10'd100);

    // Random play.
    do_reset();
    rand_frames(600);
    do_reset();
    press_start();
    rand_frames(600);

    idle(1, 10'd100);
    @(posedge frame_clk);
    @(posedge frame_clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
